// File: rtl/proc_clock_sequencer_if.sv
// Run-control bus for proc_clock_sequencer: requests in, clock/status out.
// The breakpoint signals exist only when PROC_CLOCK_BREAKPOINT_EN is defined.
`timescale 1ns/1ps
interface proc_clock_sequencer_if #(
   parameter int STEP_W = 8
`ifdef PROC_CLOCK_BREAKPOINT_EN
  ,parameter int PC_W   = 32
`endif
);
   logic              run_req;
   logic              halt_req;
   logic              step_req;
   logic [STEP_W-1:0] step_num;
   logic              c0;
   logic              tick;
   logic              locked;
   logic              busy;
   logic [1:0]        state;
   logic [31:0]       cycle_count;
`ifdef PROC_CLOCK_BREAKPOINT_EN
   logic              bp_en;
   logic [PC_W-1:0]   bp_addr;
   logic [PC_W-1:0]   pc;
   logic              bp_hit;

   modport master (
      output run_req, halt_req, step_req, step_num, bp_en, bp_addr, pc,
      input  c0, tick, locked, busy, state, cycle_count, bp_hit
   );
   modport slave (
      input  run_req, halt_req, step_req, step_num, bp_en, bp_addr, pc,
      output c0, tick, locked, busy, state, cycle_count, bp_hit
   );
`else
   modport master (
      output run_req, halt_req, step_req, step_num,
      input  c0, tick, locked, busy, state, cycle_count
   );
   modport slave (
      input  run_req, halt_req, step_req, step_num,
      output c0, tick, locked, busy, state, cycle_count
   );
`endif
endinterface

// File: rtl/proc_clock_sequencer.sv
// Processor clock run-control: divides inclk0 into c0 (+ tick strobe) and
// gates it with RUN / HALT / N-cycle STEP. A stop always waits for the
// current c0 high phase to finish, so no processor cycle is ever cut short.
// Optional breakpoint stop is enabled with `define PROC_CLOCK_BREAKPOINT_EN.
//
//   state    | meaning
//   HALT     | c0 parked low, divider cleared (locked)
//   RUN      | c0 free-running
//   STEP     | c0 running, counting down remaining processor cycles
//   STOPPING | finishing the current c0 high phase before HALT
`timescale 1ns/1ps
module proc_clock_sequencer #(
   parameter int DIV_COUNT = 500000,
   parameter int CNT_W     = 26,
   parameter int STEP_W    = 8,
   parameter int AUTO_RUN  = 1
`ifdef PROC_CLOCK_BREAKPOINT_EN
  ,parameter int PC_W      = 32
`endif
) (
   input logic                   inclk0,
   input logic                   resetn,
   proc_clock_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      ST_HALT     = 2'b00,
      ST_RUN      = 2'b01,
      ST_STEP     = 2'b10,
      ST_STOPPING = 2'b11
   } state_t;

   localparam state_t           RST_STATE = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_COUNT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_c0;
   logic              r_tick;
   logic [STEP_W-1:0] r_remaining;
   logic [31:0]       r_cycle_count;
   logic              w_wrap;
   logic              w_step_ok;
   logic              w_stop_req;
   logic              w_count_en;
   logic              w_locked;
   logic              w_busy;

   assign w_wrap    = (r_cnt == CNT_LAST);
   assign w_step_ok = (bus.step_num != '0);

`ifdef PROC_CLOCK_BREAKPOINT_EN
   logic r_bp_hit;
   logic w_bp_match;

   assign w_bp_match = r_tick && ((r_state == ST_RUN) || (r_state == ST_STEP)) &&
                       bus.bp_en && (bus.pc == bus.bp_addr);
   assign w_stop_req = bus.halt_req || w_bp_match;

   // Sticky hit flag, cleared when HALT is left by an accepted run/step
   always_ff @(posedge inclk0 or negedge resetn) begin
      if (!resetn)
         r_bp_hit <= 1'b0;
      else if (w_bp_match)
         r_bp_hit <= 1'b1;
      else if ((r_state == ST_HALT) && (w_state_nxt != ST_HALT))
         r_bp_hit <= 1'b0;
   end

   assign bus.bp_hit = r_bp_hit;
`else
   assign w_stop_req = bus.halt_req;
`endif

   // State register
   always_ff @(posedge inclk0 or negedge resetn) begin
      if (!resetn)
         r_state <= RST_STATE;
      else
         r_state <= w_state_nxt;
   end

   // Next state: halt (or breakpoint) > step > run
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_HALT: begin
            if (bus.halt_req)
               w_state_nxt = ST_HALT;
            else if (bus.step_req) begin
               if (w_step_ok)
                  w_state_nxt = ST_STEP;
            end else if (bus.run_req)
               w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_stop_req)
               w_state_nxt = ST_STOPPING;
         end
         ST_STEP: begin
            if (w_stop_req)
               w_state_nxt = ST_STOPPING;
            else if (bus.run_req)
               w_state_nxt = ST_RUN;
            else if (r_tick && (r_remaining == STEP_W'(1)))
               w_state_nxt = ST_STOPPING;
         end
         ST_STOPPING: begin
            // c0 already low: nothing to finish. Otherwise leave on the falling toggle.
            if (!r_c0 || w_wrap)
               w_state_nxt = ST_HALT;
         end
         default: w_state_nxt = RST_STATE;
      endcase
   end

   // State decode: status flags and divider enable
   always_comb begin
      w_locked   = (r_state == ST_HALT);
      w_busy     = (r_state == ST_STEP) || (r_state == ST_STOPPING);
      w_count_en = (r_state == ST_RUN) || (r_state == ST_STEP) ||
                   ((r_state == ST_STOPPING) && r_c0);
   end

   // Divider; tick is registered alongside the rising toggle of c0
   always_ff @(posedge inclk0 or negedge resetn) begin
      if (!resetn) begin
         r_cnt  <= '0;
         r_c0   <= 1'b0;
         r_tick <= 1'b0;
      end else if (w_count_en) begin
         if (w_wrap) begin
            r_cnt  <= '0;
            r_c0   <= ~r_c0;
            r_tick <= ~r_c0;
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
         end
      end else begin
         r_cnt  <= '0;
         r_c0   <= 1'b0;
         r_tick <= 1'b0;
      end
   end

   // Step budget: loaded from HALT, decremented per tick, dropped on early exit
   always_ff @(posedge inclk0 or negedge resetn) begin
      if (!resetn)
         r_remaining <= '0;
      else begin
         case (r_state)
            ST_HALT: begin
               if (!bus.halt_req && bus.step_req && w_step_ok)
                  r_remaining <= bus.step_num;
            end
            ST_STEP: begin
               if (w_stop_req || bus.run_req)
                  r_remaining <= '0;
               else if (r_tick)
                  r_remaining <= r_remaining - STEP_W'(1);
            end
            default: r_remaining <= r_remaining;
         endcase
      end
   end

   // Processor cycle counter, wraps naturally
   always_ff @(posedge inclk0 or negedge resetn) begin
      if (!resetn)
         r_cycle_count <= '0;
      else if (r_tick)
         r_cycle_count <= r_cycle_count + 32'd1;
   end

   assign bus.c0          = r_c0;
   assign bus.tick        = r_tick;
   assign bus.locked      = w_locked;
   assign bus.busy        = w_busy;
   assign bus.state       = r_state;
   assign bus.cycle_count = r_cycle_count;
endmodule

// File: doc/proc_clock_sequencer.md
Name: proc_clock_sequencer

Overview:
- Run-control sequencer for the processor clock.
- Generates the slow processor clock c0 and a one-cycle tick strobe from the fast board clock inclk0.
- Supports free RUN, HALT and N-cycle STEP so the pipeline can be paused and single-stepped from board switches or debug logic.
- Sits between the board PLL/oscillator and the processor top. The processor consumes c0 (or tick as a clock enable); locked/busy feed debug LEDs.

Parameters:
- DIV_COUNT, 500000: inclk0 cycles per c0 half-period (must be >= 2).
- CNT_W, 26: divider counter width; must hold DIV_COUNT-1.
- STEP_W, 8: width of step count.
- AUTO_RUN, 1: 1 = leave reset in RUN, 0 = leave reset in HALT.
- PC_W, 32: program-counter width (breakpoint feature only).

Ports:
- inclk0  in  1  fast board clock; all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- run_req  in  1  level-sampled request to enter RUN.
- halt_req  in  1  level-sampled request to stop.
- step_req  in  1  request to run step_num processor cycles.
- step_num  in  STEP_W  number of processor cycles for a step; sampled with step_req.
- c0  out  1  processor clock, registered, glitch-free.
- tick  out  1  one-inclk0-cycle pulse coincident with each c0 0->1 transition.
- locked  out  1  1 while state is HALT (processor clock paused).
- busy  out  1  1 while state is STEP or STOPPING.
- state  out  2  HALT=00, RUN=01, STEP=10, STOPPING=11.
- cycle_count  out  32  number of c0 rising edges since reset; wraps at 2^32.

Behaviour:
- Reset (asynchronous, resetn=0):
  - cnt=0, c0=0, tick=0, remaining=0, cycle_count=0.
  - state=RUN if AUTO_RUN else HALT; locked follows the reset state.
- Divider:
  - Counts only in RUN, STEP and STOPPING.
  - When cnt==DIV_COUNT-1: cnt<=0 and c0<=~c0. Otherwise cnt<=cnt+1.
  - c0 period = 2*DIV_COUNT inclk0 cycles; 50% duty.
  - In HALT: cnt held at 0 and c0 held at 0.
- tick: registered; tick=1 in the same inclk0 cycle that c0 first reads 1 after a toggle. tick is never 1 in two consecutive cycles.
- cycle_count: increments by 1 on every tick.
- Request priority when several are asserted in one cycle: halt_req > step_req > run_req.
- State transitions take effect on the next inclk0 edge.
- HALT:
  - halt_req: stay in HALT.
  - step_req with step_num!=0: remaining<=step_num, go to STEP.
  - step_req with step_num==0: ignored, stay in HALT.
  - run_req: go to RUN.
  - First c0 rise occurs DIV_COUNT cycles after leaving HALT.
- RUN:
  - halt_req: go to STOPPING.
  - step_req and run_req: ignored.
- STEP:
  - Each tick: remaining<=remaining-1.
  - On the tick that takes remaining from 1 to 0: go to STOPPING.
  - halt_req: remaining<=0, go to STOPPING.
  - run_req (without halt_req): remaining<=0, go to RUN.
- STOPPING:
  - All requests ignored.
  - Divider keeps counting until c0 toggles 1->0; on that edge go to HALT with cnt=0.
  - If c0==0 on entry: go to HALT on the next edge. No partial high phase is ever truncated.
- Guarantee: c0 high pulses are always exactly DIV_COUNT cycles long, so every started processor cycle completes.
- Reset asserted mid-STEP or mid-STOPPING: immediate abort to reset values.

Optional Feature:
- Macro: PROC_CLOCK_BREAKPOINT_EN.
- When defined, the block adds these ports:
  - bp_en  in  1  breakpoint enable.
  - bp_addr  in  PC_W  breakpoint address.
  - pc  in  PC_W  processor program counter.
  - bp_hit  out  1  sticky breakpoint-hit flag.
- Hit condition: tick while state is RUN or STEP, bp_en=1 and pc==bp_addr.
- On a hit: bp_hit<=1, go to STOPPING (same rule as halt_req).
- bp_hit clears on run_req or step_req accepted from HALT.
- When not defined: none of these ports or this logic exist, and behaviour is exactly as above.

Test Plan (all with DIV_COUNT=4, AUTO_RUN=0):
- Release resetn, no requests for 50 cycles -> state=HALT, locked=1, c0=0, cycle_count=0.
- Pulse run_req 1 cycle -> c0 rises 4 cycles after the state change, then period 8. tick pulses once per rise. After 5 rises cycle_count=5.
- From HALT, step_req with step_num=3 -> exactly 3 c0 high pulses, each 4 cycles wide, then state=HALT, locked=1, cycle_count=3, busy=1 throughout.
- In RUN, assert halt_req 1 cycle after a c0 rise -> state=STOPPING, c0 stays high a full 4 cycles, then c0=0 and HALT with cnt=0.
- halt_req, step_req (step_num=2) and run_req asserted in the same cycle in HALT -> stays HALT. step_req with step_num=0 -> stays HALT.
- With PROC_CLOCK_BREAKPOINT_EN, bp_addr=0x10, pc driven to 0x10 at the 3rd tick in RUN -> bp_hit=1, HALT after c0 falls, cycle_count=3. A later run_req clears bp_hit.
